commit_trace_buffer: RTL

Synthesizable retirement-trace unit for the next-generation (pipelined) cpu. It samples one retirement event per cycle from the writeback stage and classifies it as register write, load, store, halt or other. It stamps each event with an instruction number and pushes the resulting record into a parametrised FIFO that a host or debug port drains through a valid/ready handshake. It also keeps cycle and instruction counters, a sticky overflow flag, a cycle-limit watchdog, and a halt-then-drain completion sequence.

---
 rtl/commit_trace_buffer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// =============================================================================
// Module   : commit_trace_buffer
// Function : Classifies retirement events into trace records and buffers them
//            in a FIFO drained via valid/ready, with counters and completion FSM.
// Revision : 1.0
// =============================================================================
module commit_trace_buffer #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 8,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ret_valid_i,
   input  logic [DATA_W-1:0] ret_pc_i,
   input  logic              ret_regwrite_i,
   input  logic              ret_memread_i,
   input  logic              ret_memwrite_i,
   input  logic              ret_halt_i,
   input  logic [3:0]        ret_wreg_i,
   input  logic [DATA_W-1:0] ret_wdata_i,
   input  logic [DATA_W-1:0] ret_memaddr_i,
   input  logic [DATA_W-1:0] ret_memdata_i,
   input  logic              rec_ready_i,
   output logic              rec_valid_o,
   output logic [2:0]        rec_type_o,
   output logic [CNT_W-1:0]  rec_inum_o,
   output logic [DATA_W-1:0] rec_pc_o,
   output logic [3:0]        rec_reg_o,
   output logic [DATA_W-1:0] rec_value_o,
   output logic [DATA_W-1:0] rec_addr_o,
   output logic [CNT_W-1:0]  cycle_count_o,
   output logic [CNT_W-1:0]  inst_count_o,
   output logic [CNT_W-1:0]  drop_count_o,
   output logic              overflow_o,
   output logic              done_o,
   output logic              timeout_o
);

   localparam int                 PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 OCC_W      = PTR_W + 1;
   localparam logic [OCC_W-1:0]   C_FULL     = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0]   C_LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);
   localparam logic [2:0]         C_T_OTHER  = 3'd0;
   localparam logic [2:0]         C_T_REG    = 3'd1;
   localparam logic [2:0]         C_T_LOAD   = 3'd2;
   localparam logic [2:0]         C_T_STORE  = 3'd3;
   localparam logic [2:0]         C_T_HALT   = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0]        rtype;
      logic [CNT_W-1:0]  inum;
      logic [DATA_W-1:0] pc;
      logic [3:0]        rreg;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] addr;
   } rec_t;

   state_e            state_q;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [CNT_W-1:0]  cycle_q, inst_q, drop_q;
   logic              overflow_q, done_q, timeout_q;
   rec_t              mem_q [DEPTH];

   rec_t              w_new;
   rec_t              w_head;
   logic              w_accept, w_empty, w_full, w_pop, w_push, w_drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Classification: halt wins, then load, then plain register write, then store.
   always_comb begin
      w_new      = '0;
      w_new.inum = inst_q;
      w_new.pc   = ret_pc_i;
      if (ret_halt_i) begin
         w_new.rtype = C_T_HALT;
      end else if (ret_regwrite_i && ret_memread_i) begin
         w_new.rtype = C_T_LOAD;
         w_new.rreg  = ret_wreg_i;
         w_new.value = ret_wdata_i;
         w_new.addr  = ret_memaddr_i;
      end else if (ret_regwrite_i) begin
         w_new.rtype = C_T_REG;
         w_new.rreg  = ret_wreg_i;
         w_new.value = ret_wdata_i;
      end else if (ret_memwrite_i) begin
         w_new.rtype = C_T_STORE;
         w_new.value = ret_memdata_i;
         w_new.addr  = ret_memaddr_i;
      end else begin
         w_new.rtype = C_T_OTHER;
      end
   end

   assign w_accept = ret_valid_i && (state_q == ST_RUN);
   assign w_empty  = (occ_q == '0);
   assign w_full   = (occ_q == C_FULL);
   assign w_pop    = !w_empty && rec_ready_i;
   // A full FIFO still takes the push when the head leaves in the same cycle.
   assign w_push   = w_accept && (!w_full || w_pop);
   assign w_drop   = w_accept && w_full && !w_pop;

   always_comb begin
      rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      occ_d    = occ_q;
      case ({w_push, w_pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         cycle_q    <= '0;
         inst_q     <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         if (w_accept) begin
            inst_q <= sat_inc(inst_q);
         end
         if (w_drop) begin
            drop_q     <= sat_inc(drop_q);
            overflow_q <= 1'b1;
         end
         if (state_q == ST_RUN || state_q == ST_DRAIN) begin
            cycle_q <= sat_inc(cycle_q);
         end
         case (state_q)
            ST_RUN: begin
               if (w_accept && ret_halt_i) begin
                  state_q <= ST_DRAIN;
               end else if (cycle_q == C_LIMIT_M1) begin
                  state_q   <= ST_TIMEOUT;
                  timeout_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               // Looking at next occupancy lets the emptying pop itself complete the drain.
               if (occ_d == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_head        = w_empty ? '0 : mem_q[rd_ptr_q];
   assign rec_valid_o   = !w_empty;
   assign rec_type_o    = w_head.rtype;
   assign rec_inum_o    = w_head.inum;
   assign rec_pc_o      = w_head.pc;
   assign rec_reg_o     = w_head.rreg;
   assign rec_value_o   = w_head.value;
   assign rec_addr_o    = w_head.addr;
   assign cycle_count_o = cycle_q;
   assign inst_count_o  = inst_q;
   assign drop_count_o  = drop_q;
   assign overflow_o    = overflow_q;
   assign done_o        = done_q;
   assign timeout_o     = timeout_q;

endmodule
`default_nettype wire
